// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem read at a time, feeding an in-order buffer toward decode.
// Define FETCH_ILLEGAL_CHK_EN to tag each fetched word whose low bits mark a non-32-bit encoding.

module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2            // 2 or 4 only
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready,
    output logic        id_illegal
);

    localparam int               PTR_W      = $clog2(FIFO_DEPTH);
    localparam int               CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      RESET_ADDR = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

    state_t           state;
    logic [31:0]      pc;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      pc_mem    [FIFO_DEPTH];
    logic [31:0]      instr_mem [FIFO_DEPTH];

    logic             push;
    logic             pop;
    logic             space;
    logic [CNT_W-1:0] count_next;
    logic [31:0]      target;
    logic [31:0]      pc_inc;
    logic             unused_redirect_lsb;

    assign target              = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign pc_inc              = pc + 32'd4;

    // A redirect voids both the push of same-cycle ack data and any same-cycle pop.
    assign push       = (state == REQ) && imem_ack && !redirect_valid;
    assign pop        = id_valid && id_ready && !redirect_valid;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign space      = count_next < DEPTH_C;

    assign id_valid = (count != '0);
    assign id_instr = instr_mem[rd_ptr];
    assign id_pc    = pc_mem[rd_ptr];

    // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_ADDR;
            pc        <= RESET_ADDR;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc        <= target;
                        imem_addr <= target;
                        imem_req  <= 1'b1;
                        state     <= REQ;
                    end else if (space) begin
                        imem_addr <= pc;
                        imem_req  <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        pc <= target;
                        if (imem_ack) begin
                            imem_addr <= target;
                        end else begin
                            state <= FLUSH;  // old request stays on the bus until acked
                        end
                    end else if (imem_ack) begin
                        pc <= pc_inc;
                        if (space) begin
                            imem_addr <= pc_inc;
                        end else begin
                            imem_req <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (redirect_valid) begin
                        pc <= target;
                    end
                    if (imem_ack) begin
                        imem_addr <= redirect_valid ? target : pc;
                        state     <= REQ;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // NOTE: the buffer is only a few entries, so it is reset to give defined head outputs in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= imem_addr;
                instr_mem[wr_ptr] <= imem_rdata;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

`ifdef FETCH_ILLEGAL_CHK_EN
    logic ill_mem [FIFO_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ill_mem[i] <= 1'b0;
            end
        end else if (push) begin
            ill_mem[wr_ptr] <= (imem_rdata[1:0] != 2'b11);
        end
    end

    assign id_illegal = ill_mem[rd_ptr];
`else
    assign id_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: bus responder with wait states plus a sequential-stream model.
// Honours FETCH_ILLEGAL_CHK_EN when expecting id_illegal.

module tb_instr_fetch;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
`ifdef FETCH_ILLEGAL_CHK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        id_illegal;

    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_ack2;
    logic [31:0] imem_rdata2;
    logic        redirect_valid2;
    logic [31:0] redirect_pc2;
    logic        id_valid2;
    logic [31:0] id_instr2;
    logic [31:0] id_pc2;
    logic        id_ready2;
    logic        id_illegal2;

    int          total = 0;
    int          bad = 0;
    int          taken = 0;
    int          n_acks = 0;
    int          fixed_wait = 0;
    bit          rand_waits = 1'b0;
    bit          junk_ack = 1'b0;
    logic [31:0] exp_pc = 32'h0;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
        .id_illegal(id_illegal)
    );

    instr_fetch #(.RESET_PC(WRAP_PC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .id_valid(id_valid2), .id_instr(id_instr2), .id_pc(id_pc2), .id_ready(id_ready2),
        .id_illegal(id_illegal2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h200) return 32'h0000_0001;
        if (a == 32'h204) return 32'h0000_0013;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // Second instance: zero-wait memory, always ready, no redirects.
    initial begin
        imem_ack2       = 1'b1;
        imem_rdata2     = 32'h0000_0013;
        redirect_valid2 = 1'b0;
        redirect_pc2    = 32'h0;
        id_ready2       = 1'b1;
    end

    // Memory responder: answers each request after a configurable number of wait states.
    initial begin
        int          wcnt;
        int          cur_wait;
        bit          req_open;
        logic [31:0] held_addr;
        wcnt = 0; cur_wait = 0; req_open = 1'b0; held_addr = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n || !imem_req) begin
                imem_ack   = junk_ack;
                imem_rdata = $urandom;
                wcnt       = 0;
                req_open   = 1'b0;
            end else begin
                total++;
                if (imem_addr[1:0] !== 2'b00) begin
                    bad++;
                    $display("FAIL addr_align: imem_addr=%h required low bits 00", imem_addr);
                end
                if (!req_open) begin
                    req_open  = 1'b1;
                    held_addr = imem_addr;
                    cur_wait  = rand_waits ? int'($urandom_range(0, 3)) : fixed_wait;
                    wcnt      = 0;
                end else begin
                    total++;
                    if (imem_addr !== held_addr) begin
                        bad++;
                        $display("FAIL addr_hold: imem_addr=%h required=%h", imem_addr, held_addr);
                    end
                end
                if (wcnt >= cur_wait) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_fn(imem_addr);
                    req_open   = 1'b0;
                    n_acks++;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    wcnt++;
                end
            end
        end
    end

    // One clock cycle of decode-side stimulus; every accepted head is checked against the
    // expected sequential stream, which restarts at the aligned target on a redirect.
    task automatic tick(input logic rdy, input logic rv, input logic [31:0] rt);
        logic [31:0] exp_instr;
        logic        exp_ill;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rt;
        if (id_valid && rdy && !rv) begin
            exp_instr = mem_fn(exp_pc);
            exp_ill   = ILL_EN && (exp_instr[1:0] != 2'b11);
            total++;
            if (id_pc !== exp_pc) begin
                bad++;
                $display("FAIL stream_pc: id_pc=%h required=%h", id_pc, exp_pc);
            end
            total++;
            if (id_instr !== exp_instr) begin
                bad++;
                $display("FAIL stream_instr: id_instr=%h required=%h", id_instr, exp_instr);
            end
            total++;
            if (id_illegal !== exp_ill) begin
                bad++;
                $display("FAIL stream_illegal: id_illegal=%b required=%b", id_illegal, exp_ill);
            end
            exp_pc = exp_pc + 32'd4;
            taken++;
        end
        if (rv) exp_pc = {rt[31:2], 2'b00};
        @(negedge clk);
        #1;
        redirect_valid = 1'b0;
        if (rv) begin
            total++;
            if (id_valid !== 1'b0) begin
                bad++;
                $display("FAIL redirect_empty: id_valid=%b required=0", id_valid);
            end
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        rst_n  = 1'b1;
        exp_pc = 32'h0;
    endtask

    task automatic test_reset();
        int t0;
        fixed_wait     = 3;
        rand_waits     = 1'b0;
        junk_ack       = 1'b1;
        rst_n          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({imem_req, id_valid, id_illegal} !== 3'b000 || imem_addr !== 32'h0 ||
            id_instr !== 32'h0 || id_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: req=%b valid=%b ill=%b addr=%h instr=%h pc=%h required all zero",
                     imem_req, id_valid, id_illegal, imem_addr, id_instr, id_pc);
        end
        total++;
        if (imem_addr2 !== WRAP_PC || imem_req2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_addr_param: imem_addr=%h req=%b required=%h req=0", imem_addr2, imem_req2, WRAP_PC);
        end
        rst_n  = 1'b1;
        exp_pc = 32'h0;
        tick(1'b1, 1'b0, 32'h0);
        junk_ack = 1'b0;
        total++;
        if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_first_fetch: valid=%b req=%b addr=%h required valid=0 req=1 addr=0",
                     id_valid, imem_req, imem_addr);
        end
        tick(1'b1, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || id_valid !== 1'b0 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_request: req=%b valid=%b addr=%h required 0 0 0", imem_req, id_valid, imem_addr);
        end
        fixed_wait = 0;
        do_reset();
        t0 = taken;
        repeat (4) tick(1'b1, 1'b0, 32'h0);
        total++;
        if (taken - t0 !== 2) begin
            bad++;
            $display("FAIL reset_restart_count: transfers=%0d required=2", taken - t0);
        end
    endtask

    task automatic test_stream();
        int t0;
        fixed_wait = 0;
        do_reset();
        t0 = taken;
        tick(1'b1, 1'b0, 32'h0);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL stream_addr0: req=%b addr=%h required req=1 addr=0", imem_req, imem_addr);
        end
        tick(1'b1, 1'b0, 32'h0);
        total++;
        if (imem_addr !== 32'h4 || id_valid !== 1'b1 || id_pc !== 32'h0) begin
            bad++;
            $display("FAIL stream_addr4: addr=%h valid=%b id_pc=%h required 4 1 0", imem_addr, id_valid, id_pc);
        end
        tick(1'b1, 1'b0, 32'h0);
        total++;
        if (imem_addr !== 32'h8) begin
            bad++;
            $display("FAIL stream_addr8: addr=%h required=8", imem_addr);
        end
        repeat (19) tick(1'b1, 1'b0, 32'h0);
        total++;
        if (taken - t0 !== 20) begin
            bad++;
            $display("FAIL stream_throughput: transfers=%0d required=20", taken - t0);
        end
    endtask

    task automatic test_stall();
        int a0;
        fixed_wait = 0;
        do_reset();
        a0 = n_acks;
        repeat (10) tick(1'b0, 1'b0, 32'h0);
        total++;
        if (imem_req !== 1'b0 || n_acks - a0 !== 2 || id_valid !== 1'b1 || id_pc !== 32'h0) begin
            bad++;
            $display("FAIL stall_full: req=%b acks=%0d valid=%b id_pc=%h required req=0 acks=2 valid=1 pc=0",
                     imem_req, n_acks - a0, id_valid, id_pc);
        end
        tick(1'b1, 1'b0, 32'h0);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || id_pc !== 32'h4) begin
            bad++;
            $display("FAIL stall_resume: req=%b addr=%h id_pc=%h required req=1 addr=8 pc=4",
                     imem_req, imem_addr, id_pc);
        end
        repeat (6) tick(1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_redirect_wait();
        bit found;
        fixed_wait = 3;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (imem_req && imem_addr == 32'h4) begin
                found = 1'b1;
                break;
            end
            tick(1'b1, 1'b0, 32'h0);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL redir_wait_start: request to 0x4 not seen, required within 30 cycles");
        end
        tick(1'b1, 1'b1, 32'h103);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            bad++;
            $display("FAIL redir_flush_hold: req=%b addr=%h required req=1 addr=4", imem_req, imem_addr);
        end
        for (int k = 0; k < 30; k++) begin
            if (imem_addr != 32'h4) break;
            tick(1'b1, 1'b0, 32'h0);
        end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || id_valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_next_addr: req=%b addr=%h valid=%b required req=1 addr=100 valid=0",
                     imem_req, imem_addr, id_valid);
        end
        for (int k = 0; k < 30; k++) begin
            if (id_valid) break;
            tick(1'b1, 1'b0, 32'h0);
        end
        total++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100) begin
            bad++;
            $display("FAIL redir_first_pc: valid=%b id_pc=%h required valid=1 pc=100", id_valid, id_pc);
        end
        repeat (4) tick(1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_redirect_full();
        int t0;
        fixed_wait = 0;
        do_reset();
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        total++;
        if (id_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            bad++;
            $display("FAIL full_setup: valid=%b req=%b addr=%h required 1 1 4", id_valid, imem_req, imem_addr);
        end
        tick(1'b0, 1'b1, 32'h342);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h340) begin
            bad++;
            $display("FAIL full_redirect_addr: req=%b addr=%h required req=1 addr=340", imem_req, imem_addr);
        end
        t0 = taken;
        repeat (5) tick(1'b1, 1'b0, 32'h0);
        total++;
        if (taken - t0 !== 4) begin
            bad++;
            $display("FAIL full_refill: transfers=%0d required=4", taken - t0);
        end
    endtask

    task automatic test_illegal();
        fixed_wait = 0;
        do_reset();
        tick(1'b0, 1'b1, 32'h200);
        tick(1'b0, 1'b0, 32'h0);
        total++;
        if (id_pc !== 32'h200 || id_instr !== 32'h1 || id_illegal !== ILL_EN) begin
            bad++;
            $display("FAIL illegal_flag: pc=%h instr=%h ill=%b required pc=200 instr=1 ill=%b",
                     id_pc, id_instr, id_illegal, ILL_EN);
        end
        tick(1'b1, 1'b0, 32'h0);
        total++;
        if (id_pc !== 32'h204 || id_instr !== 32'h13 || id_illegal !== 1'b0) begin
            bad++;
            $display("FAIL legal_flag: pc=%h instr=%h ill=%b required pc=204 instr=13 ill=0",
                     id_pc, id_instr, id_illegal);
        end
        repeat (3) tick(1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_wrap();
        do_reset();
        tick(1'b1, 1'b0, 32'h0);
        total++;
        if (imem_req2 !== 1'b1 || imem_addr2 !== WRAP_PC) begin
            bad++;
            $display("FAIL wrap_first: req=%b addr=%h required req=1 addr=%h", imem_req2, imem_addr2, WRAP_PC);
        end
        tick(1'b1, 1'b0, 32'h0);
        total++;
        if (imem_addr2 !== 32'h0 || id_valid2 !== 1'b1 || id_pc2 !== WRAP_PC || id_instr2 !== 32'h13) begin
            bad++;
            $display("FAIL wrap_second: addr=%h valid=%b id_pc=%h instr=%h required addr=0 valid=1 pc=%h instr=13",
                     imem_addr2, id_valid2, id_pc2, id_instr2, WRAP_PC);
        end
        tick(1'b1, 1'b0, 32'h0);
        total++;
        if (imem_addr2 !== 32'h4 || id_pc2 !== 32'h0 || id_illegal2 !== 1'b0) begin
            bad++;
            $display("FAIL wrap_third: addr=%h id_pc=%h ill=%b required addr=4 pc=0 ill=0",
                     imem_addr2, id_pc2, id_illegal2);
        end
    endtask

    task automatic test_random();
        int          t0;
        logic        rdy;
        logic        rv;
        logic [31:0] rt;
        rand_waits = 1'b1;
        do_reset();
        t0 = taken;
        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 24) == 0);
            rt  = $urandom;
            tick(rdy, rv, rt);
        end
        rand_waits = 1'b0;
        total++;
        if (taken - t0 < 60) begin
            bad++;
            $display("FAIL random_progress: transfers=%0d required at least 60", taken - t0);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_full();
        test_illegal();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
